// File: rtl/fb_fetch.sv
// ============================================================================
// fb_fetch : framebuffer fetch unit, RGB565 burst fetch into a FIFO, 24-bit
//            pixel out per strobe, sticky underrun/overrun flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fb_fetch #(
    parameter int DEPTH_N = 5,
    parameter int BURST   = 4,
    parameter int AW      = 24
) (
    input  logic               clkSYS,
    input  logic               reset,
    input  logic               frame,
    input  logic               pixel,
    input  logic [AW-1:0]      base,
    input  logic [AW-1:0]      words,
    output logic               req,
    output logic [AW-1:0]      addr,
    input  logic               rdy,
    input  logic               ifrdy,
    input  logic [15:0]        data,
    output logic [23:0]        out,
    output logic [DEPTH_N:0]   level,
    output logic               underrun,
    output logic               overrun,
    input  logic               clr_err
);

    localparam int                SLOTS    = 2 ** DEPTH_N;
    localparam logic [DEPTH_N:0]  FULL_CNT = (DEPTH_N+1)'(SLOTS);
    localparam logic [DEPTH_N:0]  REQ_MAX  = (DEPTH_N+1)'(SLOTS - BURST);
    localparam logic [DEPTH_N:0]  BURST_L  = (DEPTH_N+1)'(BURST);
    localparam logic [DEPTH_N:0]  ONE_L    = (DEPTH_N+1)'(1);
    localparam logic [AW-1:0]     BURST_A  = AW'(BURST);

    logic [15:0]          mem [SLOTS];
    logic [DEPTH_N-1:0]   head;
    logic [DEPTH_N-1:0]   tail;
    logic [DEPTH_N:0]     count;
    logic [AW-1:0]        offset;
    logic [AW-1:0]        base_q;
    logic [AW-1:0]        words_q;
    logic                 done;

    logic                 full;
    logic                 empty;
    logic                 accept;
    logic                 pop_ok;
    logic                 push_ok;
    logic                 under_ev;
    logic                 over_ev;
    logic [AW-1:0]        next_off;

    function automatic logic [23:0] expand(input logic [15:0] w);
        return {w[15:11], w[15:13], w[10:5], w[10:9], w[4:0], w[4:2]};
    endfunction

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    // Request decodes only registered state and frame; rdy merely qualifies acceptance.
    assign req      = ~frame & ~done & (words_q != '0) & (level <= REQ_MAX);
    assign accept   = req & rdy;
    assign addr     = base_q + offset;
    assign next_off = offset + BURST_A;

    // A pop at full frees the slot being written, so push and pop coexist.
    assign pop_ok   = ~frame & pixel & ~empty;
    assign under_ev = ~frame & pixel & empty;
    assign push_ok  = ~frame & ifrdy & (~full | pop_ok);
    assign over_ev  = ~frame & ifrdy & full & ~pop_ok;

    always_ff @(posedge clkSYS) begin
        if (push_ok) begin
            mem[head] <= data;
        end
    end

    always_ff @(posedge clkSYS) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            level    <= '0;
            offset   <= '0;
            base_q   <= '0;
            words_q  <= '0;
            done     <= 1'b1;
            out      <= '0;
            underrun <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            underrun <= (underrun & ~clr_err) | under_ev;
            overrun  <= (overrun & ~clr_err) | over_ev;
            if (frame) begin
                head    <= '0;
                tail    <= '0;
                count   <= '0;
                level   <= '0;
                offset  <= '0;
                done    <= 1'b0;
                base_q  <= base;
                words_q <= words;
            end else begin
                if (push_ok) begin
                    head <= head + 1'b1;
                end
                if (pop_ok) begin
                    tail <= tail + 1'b1;
                    out  <= expand(mem[tail]);
                end else if (under_ev) begin
                    out  <= '0;
                end
                count <= count + (DEPTH_N+1)'(push_ok) - (DEPTH_N+1)'(pop_ok);

                if (accept && pop_ok) begin
                    level <= level + BURST_L - ONE_L;
                end else if (accept) begin
                    level <= level + BURST_L;
                end else if (pop_ok) begin
                    level <= level - ONE_L;
                end

                if (accept) begin
                    offset <= next_off;
                    if (next_off == words_q) begin
                        done <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fb_fetch.sv
// ============================================================================
// tb_fb_fetch : randomized scoreboard bench for fb_fetch with a queue-based
//               reference model of the fetch unit and memory side.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_fb_fetch;

    localparam int DEPTH_N = 5;
    localparam int BURST   = 4;
    localparam int AW      = 24;
    localparam int SLOTS   = 32;

    logic              clkSYS = 1'b0;
    logic              reset  = 1'b1;
    logic              frame  = 1'b0;
    logic              pixel  = 1'b0;
    logic [AW-1:0]     base   = '0;
    logic [AW-1:0]     words  = '0;
    logic              rdy    = 1'b0;
    logic              ifrdy  = 1'b0;
    logic [15:0]       data   = '0;
    logic              clr_err = 1'b0;
    logic              req;
    logic [AW-1:0]     addr;
    logic [23:0]       out;
    logic [DEPTH_N:0]  level;
    logic              underrun;
    logic              overrun;

    fb_fetch #(.DEPTH_N(DEPTH_N), .BURST(BURST), .AW(AW)) dut (
        .clkSYS(clkSYS), .reset(reset), .frame(frame), .pixel(pixel),
        .base(base), .words(words), .req(req), .addr(addr), .rdy(rdy),
        .ifrdy(ifrdy), .data(data), .out(out), .level(level),
        .underrun(underrun), .overrun(overrun), .clr_err(clr_err)
    );

    always #5 clkSYS = ~clkSYS;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [15:0]   m_fifo[$];
    logic [15:0]   pend[$];
    logic [23:0]   expq[$];
    int            m_credit = 0;
    int            m_nreq   = 0;
    bit            m_done   = 1'b1;
    logic [AW-1:0] m_base   = '0;
    logic [AW-1:0] m_words  = '0;
    bit            m_und    = 1'b0;
    bit            m_ovr    = 1'b0;
    bit            from_pend = 1'b0;
    bit            pat_mode  = 1'b0;
    int            pat_idx   = 0;
    int            dut_acc   = 0;
    logic [AW-1:0] dut_last  = '0;
    logic [15:0]   pat [4] = '{16'hFFFF, 16'hF800, 16'h07E0, 16'h001F};
    logic [23:0]   pat_exp [4] = '{24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h0000FF};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] ref_expand(input logic [15:0] w);
        int r, g, b;
        logic [7:0] r8, g8, b8;
        r = int'(w >> 11) & 31;
        g = int'(w >> 5) & 63;
        b = int'(w) & 31;
        r8 = 8'((r << 3) | (r >> 2));
        g8 = 8'((g << 2) | (g >> 4));
        b8 = 8'((b << 3) | (b >> 2));
        return {r8, g8, b8};
    endfunction

    function automatic bit exp_req();
        return !frame && !m_done && (m_words != '0) && (m_credit <= SLOTS - BURST);
    endfunction

    task automatic model_update();
        bit acc, pop, und, push, ovr;
        acc = exp_req() && rdy;
        if (frame) begin
            m_fifo.delete();
            pend.delete();
            m_credit = 0;
            m_nreq   = 0;
            m_done   = 1'b0;
            m_base   = base;
            m_words  = words;
            m_und    = m_und && !clr_err;
            m_ovr    = m_ovr && !clr_err;
        end else begin
            pop  = pixel && (m_fifo.size() > 0);
            und  = pixel && (m_fifo.size() == 0);
            push = ifrdy && ((m_fifo.size() < SLOTS) || pop);
            ovr  = ifrdy && (m_fifo.size() == SLOTS) && !pop;
            if (pop) expq.push_back(ref_expand(m_fifo.pop_front()));
            if (und) expq.push_back(24'h0);
            if (push) m_fifo.push_back(data);
            if (ifrdy && from_pend && pend.size() > 0) void'(pend.pop_front());
            m_credit = m_credit + (acc ? BURST : 0) - (pop ? 1 : 0);
            if (acc) begin
                m_nreq++;
                if (m_nreq * BURST == int'(m_words)) m_done = 1'b1;
                for (int i = 0; i < BURST; i++) begin
                    pend.push_back(pat_mode ? pat[pat_idx % 4] : 16'($urandom));
                    pat_idx++;
                end
            end
            m_und = (m_und && !clr_err) || und;
            m_ovr = (m_ovr && !clr_err) || ovr;
        end
    endtask

    task automatic step();
        logic [AW-1:0] ea;
        #1;
        ea = m_base + AW'(m_nreq * BURST);
        check("req", 32'(req), 32'(exp_req()));
        if (exp_req()) check("addr", 32'(addr), 32'(ea));
        check("level", 32'(level), m_credit);
        check("underrun", 32'(underrun), 32'(m_und));
        check("overrun", 32'(overrun), 32'(m_ovr));
        if (req && rdy) begin
            dut_acc++;
            dut_last = addr;
        end
        @(posedge clkSYS);
        model_update();
        @(negedge clkSYS);
    endtask

    task automatic idle();
        frame = 0; pixel = 0; ifrdy = 0; rdy = 0; clr_err = 0; from_pend = 0;
    endtask

    task automatic do_frame(input logic [AW-1:0] b, input logic [AW-1:0] w);
        idle();
        dut_acc = 0;
        frame = 1; base = b; words = w;
        repeat (2) step();
        frame = 0;
    endtask

    task automatic feed_pend();
        ifrdy = 1; from_pend = 1; data = pend[0];
    endtask

    task automatic drive_rand();
        rdy = 1'($urandom % 2);
        if (pend.size() > 0 && ($urandom % 3) != 0) feed_pend();
        else begin
            ifrdy = 0; from_pend = 0;
        end
        pixel = (m_fifo.size() > 0) && (($urandom % 2) == 1);
    endtask

    // Scoreboard monitor: every accepted pixel strobe yields one checked output
    initial begin
        forever begin
            @(posedge clkSYS);
            if (!reset && !frame && pixel) begin
                @(negedge clkSYS);
                if (expq.size() == 0) check("pixel_unexpected", 32'(out), 32'hFFFFFFFF);
                else check("pixel", 32'(out), 32'(expq.pop_front()));
            end
        end
    end

    initial begin
        int cyc;
        repeat (3) @(posedge clkSYS);
        @(negedge clkSYS);
        check("rst_req", 32'(req), 0);
        check("rst_out", 32'(out), 0);
        check("rst_level", 32'(level), 0);
        check("rst_und", 32'(underrun), 0);
        check("rst_ovr", 32'(overrun), 0);
        reset = 0;
        step();

        // Initial fill: eight bursts with rdy tied high
        pat_mode = 1;
        do_frame(24'hF00000, 24'd64);
        rdy = 1;
        repeat (12) step();
        check("acc_fill", dut_acc, 8);
        check("level_full", 32'(level), 32);

        // Directed words and expansion
        rdy = 0;
        for (int i = 0; i < 4; i++) begin
            feed_pend();
            step();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            pixel = 1;
            step();
            check("dir_out", 32'(out), 32'(pat_exp[i]));
        end
        pixel = 0;
        #1;
        check("level_28", 32'(level), 28);
        check("req_reassert", 32'(req), 1);
        @(negedge clkSYS);

        // Remainder of the frame under random traffic
        pat_mode = 0;
        cyc = 0;
        while (!(m_done && pend.size() == 0 && m_fifo.size() == 0) && cyc < 5000) begin
            drive_rand();
            step();
            cyc++;
        end
        check("frame_timeout", 32'(cyc < 5000), 1);
        idle();
        repeat (2) step();
        check("acc_total", dut_acc, 16);
        check("last_addr", 32'(dut_last), 32'hF0003C);
        check("done_req", 32'(req), 0);

        // Underrun and clear priority
        pixel = 1; step(); pixel = 0;
        check("und_out", 32'(out), 0);
        check("und_set", 32'(underrun), 1);
        repeat (2) step();
        check("und_hold", 32'(underrun), 1);
        clr_err = 1; step(); clr_err = 0;
        check("und_clr", 32'(underrun), 0);
        pixel = 1; clr_err = 1; step(); pixel = 0; clr_err = 0;
        check("und_wins", 32'(underrun), 1);
        clr_err = 1; step(); clr_err = 0;

        // Overrun at full, and simultaneous push/pop at full
        do_frame(24'h001000, 24'd64);
        rdy = 1;
        repeat (10) step();
        rdy = 0;
        for (int i = 0; i < SLOTS; i++) begin
            feed_pend();
            step();
        end
        ifrdy = 1; from_pend = 0; data = 16'hDEAD;
        step();
        check("ovr_set", 32'(overrun), 1);
        ifrdy = 0; clr_err = 1; step(); clr_err = 0;
        ifrdy = 1; data = 16'hBEEF; pixel = 1;
        step();
        check("ovr_pushpop", 32'(overrun), 0);
        ifrdy = 0;
        for (int i = 0; i < 5; i++) begin
            pixel = 1;
            step();
        end
        pixel = 0;

        // Frame asserted mid-frame after five bursts
        do_frame(24'h123400, 24'd128);
        cyc = 0;
        while (m_nreq < 5 && cyc < 3000) begin
            drive_rand();
            step();
            cyc++;
        end
        check("burst5_timeout", 32'(cyc < 3000), 1);
        idle();
        frame = 1; ifrdy = 1; data = 16'h1111; pixel = 1;
        base = 24'h200000; words = 24'd64;
        step();
        check("mid_level", 32'(level), 0);
        check("mid_req", 32'(req), 0);
        check("mid_ovr", 32'(overrun), 0);
        step();
        idle();
        #1;
        check("new_base", 32'(addr), 32'h200000);
        check("new_req", 32'(req), 1);
        @(negedge clkSYS);
        repeat (3) step();
        check("sb_empty", expq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
